serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: operand width limits
// and the controller state encoding.
package serial_subtractor_pkg;

    // Default operand width and the legal range for the WIDTH parameter.
    localparam int unsigned SUB_WIDTH_DEFAULT = 8;
    localparam int unsigned SUB_WIDTH_MIN     = 2;
    localparam int unsigned SUB_WIDTH_MAX     = 32;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin (mod 2), bo = borrow out.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bo     : difference bit, borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a==b and a borrow is already pending.
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH,
// bout = 1 when a < b + bin. One bit per clock, LSB first, through a single
// full_subtractor cell and a one-bit borrow register.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : begin an operation (accepted in IDLE or DONE)
//   a, b, bin     : operands and borrow-in, captured when start is accepted
//   busy          : high while bits are being processed
//   done          : one-cycle pulse when diff/bout hold a fresh result
//   diff, bout    : result, held until the next operation starts shifting
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject illegal widths at elaboration.
    if (WIDTH < SUB_WIDTH_MIN || WIDTH > SUB_WIDTH_MAX) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    sub_state_e       state;
    sub_state_e       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             fs_d;
    logic             fs_bo;

    // The single bit-slice: always looks at the current LSBs.
    full_subtractor u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (borrow),
        .d   (fs_d),
        .bo  (fs_bo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured outside SHIFT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? SHIFT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial shift, borrow chain, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff   <= {fs_d, diff[WIDTH-1:1]};
                    borrow <= fs_bo;
                    // bout tracks the borrow chain; its final value is the
                    // borrow out of the MSB.
                    bout   <= fs_bo;
                    // Saturate on the last bit so the counter never wraps.
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered alongside the state so they decode it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
        end
    end

endmodule
